rle_dec_row: RTL

- Run-length decoder that inverts the JPEG RLE encoder stage.
- Consumes a stream of {run, level} symbols, one per handshake, and expands them into 64-coefficient blocks.
- Emits blocks as eight 64-bit rows, coefficient 0 in bits [63:56], the same row format the encoder takes as input.
- Sits between the entropy-decode front end and the inverse quantiser/IDCT path.

---
 rtl/rle_pkg.sv | 24 ++
 rtl/rle_dec_row_if.sv | 25 ++
 rtl/rle_row_asm.sv | 53 +++++
 rtl/rle_dec_row.sv | 92 +++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared definitions for the JPEG run-length encoder/decoder pair.
// Symbol layout is {run, level}; an all-zero symbol marks end of block.
package rle_pkg;

  localparam int RUN_W = 6;
  localparam int VAL_W = 8;
  localparam int ROW_N = 8;
  localparam int BLK_N = 64;
  localparam int ROW_W = ROW_N * VAL_W;
  localparam int COL_W = $clog2(ROW_N);
  localparam int POS_W = $clog2(BLK_N);

  typedef struct packed {
    logic [RUN_W-1:0] run;
    logic [VAL_W-1:0] level;
  } sym_t;

  localparam sym_t EOB_SYM = 14'h0000;

  function automatic logic is_eob(sym_t s);
    return s == EOB_SYM;
  endfunction

endpackage

// File: rtl/rle_dec_row_if.sv
// Symbol-in / row-out handshake bundle of the RLE decoder.
// slave is the decoder view, master the producer/consumer view.
interface rle_dec_row_if;
  import rle_pkg::*;

  sym_t             sym_in;
  logic             sym_valid;
  logic             sym_ready;
  logic [ROW_W-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             blk_done;
  logic             err;

  modport slave (
    input  sym_in, sym_valid, out_ready,
    output sym_ready, out, out_valid, blk_done, err
  );

  modport master (
    output sym_in, sym_valid, out_ready,
    input  sym_ready, out, out_valid, blk_done, err
  );

endinterface

// File: rtl/rle_row_asm.sv
// Eight-byte row assembler: writes one coefficient per strobe and
// publishes the completed row through a valid/ready output register.
module rle_row_asm
  import rle_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [COL_W-1:0] i_col,
  input  logic [VAL_W-1:0] i_byte,
  input  logic             i_last,
  input  logic             i_out_ready,
  output logic [ROW_W-1:0] o_row,
  output logic             o_valid,
  output logic             o_blk_done
);

  logic [ROW_W-1:0] r_row;
  logic [ROW_W-1:0] w_row;
  logic             w_done;

  // Coefficient 0 sits in the top byte of the row
  always_comb begin
    w_row = r_row;
    for (int k = 0; k < ROW_N; k++) begin
      if (i_col == COL_W'(k))
        w_row[(ROW_N-1-k)*VAL_W +: VAL_W] = i_byte;
    end
  end

  assign w_done = i_we & (i_col == COL_W'(ROW_N-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row      <= '0;
      o_row      <= '0;
      o_valid    <= 1'b0;
      o_blk_done <= 1'b0;
    end else begin
      o_blk_done <= 1'b0;
      if (i_we)
        r_row <= w_row;
      if (w_done) begin
        o_row      <= w_row;
        o_valid    <= 1'b1;
        o_blk_done <= i_last;
      end else if (o_valid & i_out_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rle_dec_row.sv
// Run-length decoder: expands {run, level} symbols into 64-coefficient
// blocks delivered as eight 64-bit rows.
module rle_dec_row
  import rle_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  rle_dec_row_if.slave   bus
);

  logic [POS_W-1:0] r_pos;
  logic [RUN_W-1:0] r_zrun;
  logic [VAL_W-1:0] r_lvl;
  logic             r_have;
  logic             r_eob;
  logic             r_err;

  sym_t             w_sym;
  logic             w_stall;
  logic             w_acc;
  logic             w_prod;
  logic             w_over;
  logic             w_last;
  logic [POS_W:0]   w_sum;
  logic [VAL_W-1:0] w_byte;

  assign w_sym   = bus.sym_in;
  assign w_stall = bus.out_valid & ~bus.out_ready;

  assign bus.sym_ready = reset & ~w_stall & ~r_have
                       & (r_zrun == '0) & ~r_eob;

  assign w_acc  = bus.sym_valid & bus.sym_ready;
  assign w_sum  = {1'b0, r_pos} + (POS_W+1)'(w_sym.run);
  assign w_over = w_sum > (POS_W+1)'(BLK_N-1);
  assign w_last = r_pos == POS_W'(BLK_N-1);

  assign w_prod = ~w_stall & (r_eob | (r_zrun != '0) | r_have);
  assign w_byte = (r_eob | (r_zrun != '0)) ? '0 : r_lvl;

  // Accept never coincides with production, so the two updates are disjoint
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos  <= '0;
      r_zrun <= '0;
      r_lvl  <= '0;
      r_have <= 1'b0;
      r_eob  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_acc) begin
        if (is_eob(w_sym)) begin
          r_eob <= 1'b1;
        end else if (w_over) begin
          r_eob <= 1'b1;
          r_err <= 1'b1;
        end else begin
          r_zrun <= w_sym.run;
          r_lvl  <= w_sym.level;
          r_have <= 1'b1;
        end
      end
      if (w_prod) begin
        r_pos <= r_pos + POS_W'(1);
        if (r_eob) begin
          if (w_last)
            r_eob <= 1'b0;
        end else if (r_zrun != '0) begin
          r_zrun <= r_zrun - RUN_W'(1);
        end else begin
          r_have <= 1'b0;
        end
      end
    end
  end

  assign bus.err = r_err;

  rle_row_asm u_asm (
    .clk         (clk),
    .rst_n       (reset),
    .i_we        (w_prod),
    .i_col       (r_pos[COL_W-1:0]),
    .i_byte      (w_byte),
    .i_last      (w_last),
    .i_out_ready (bus.out_ready),
    .o_row       (bus.out),
    .o_valid     (bus.out_valid),
    .o_blk_done  (bus.blk_done)
  );

endmodule
